adder_share_arb: RTL

- Shares one 8-bit two's-complement adder with overflow detection between NREQ requesters.
- Round-robin arbitration with per-requester valid/ready handshake.
- One registered result stage tagged with the requester id, sum, and overflow flag.
- Sits between the operand producers and the single adder datapath; also keeps a saturating overflow-event count for status readback.

---
 rtl/adder_share_pkg.sv | 17 +
 rtl/signed_add_ovf.sv | 28 ++
 rtl/adder_share_arb.sv | 123 ++++++++++++
 3 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and constants for the shared signed adder / arbiter block.
// Optional clamping of overflowed sums is enabled by ADDER_SHARE_SATURATE_EN.
package adder_share_pkg;

    localparam int W_DEF   = 8;
    localparam int IDW_DEF = 2;

    localparam logic [W_DEF-1:0] SAT_POS = 8'h7F;
    localparam logic [W_DEF-1:0] SAT_NEG = 8'h80;

    typedef struct packed {
        logic [W_DEF-1:0]   data;
        logic               ovf;
        logic [IDW_DEF-1:0] id;
    } res_t;

endpackage

// File: rtl/signed_add_ovf.sv
// Combinational W-bit two's-complement adder with signed overflow flag.
// With ADDER_SHARE_SATURATE_EN defined, overflowed sums clamp to the signed extremes.
module signed_add_ovf
    import adder_share_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W-1:0] raw;

    assign raw = a + b;
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef ADDER_SHARE_SATURATE_EN
    // Overflow only happens with like-signed operands, so a's sign picks the rail.
    localparam logic [W-1:0] SAT_P = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_N = {1'b1, {(W-1){1'b0}}};
    assign sum = ovf ? (a[W-1] ? SAT_N : SAT_P) : raw;
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin sharing of one signed adder among NREQ requesters, with a single
// registered result stage and a saturating overflow-event counter.
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_data,
    output logic              res_ovf,
    output logic [IDW-1:0]    res_id,
    output logic [7:0]        ovf_count
);

    typedef struct packed {
        logic [W-1:0]   data;
        logic           ovf;
        logic [IDW-1:0] id;
    } res_rec_t;

    localparam logic [IDW:0]   NREQ_L = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

    res_rec_t       res_q, res_d;
    logic           res_valid_q, res_valid_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [7:0]     cnt_q, cnt_d;

    logic           slot_free;
    logic           found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   cand;
    logic [NREQ-1:0] gnt_oh;
    logic [W-1:0]   a_sel, b_sel, sum;
    logic           ovf;

    assign slot_free = !res_valid_q || res_ready;

    // Search from the pointer upward with wrap; first valid requester wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (!rst && slot_free) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = {1'b0, ptr_q} + (IDW+1)'(k);
                if (cand >= NREQ_L) cand = cand - NREQ_L;
                if (!found && req_valid[cand[IDW-1:0]]) begin
                    found   = 1'b1;
                    gnt_idx = cand[IDW-1:0];
                end
            end
        end
        for (int i = 0; i < NREQ; i++) gnt_oh[i] = found && (gnt_idx == IDW'(i));
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
    end

    signed_add_ovf #(.W(W)) u_add (
        .a   (a_sel),
        .b   (b_sel),
        .sum (sum),
        .ovf (ovf)
    );

    always_comb begin
        res_d       = res_q;
        res_valid_d = res_valid_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        if (res_valid_q && res_ready && res_q.ovf && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        // A grant in a draining cycle simply overwrites the departing result.
        if (found) begin
            res_d.data  = sum;
            res_d.ovf   = ovf;
            res_d.id    = gnt_idx;
            res_valid_d = 1'b1;
            ptr_d       = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q       <= '0;
            res_valid_q <= 1'b0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = gnt_oh;
    assign res_valid = res_valid_q;
    assign res_data  = res_q.data;
    assign res_ovf   = res_q.ovf;
    assign res_id    = res_q.id;
    assign ovf_count = cnt_q;

endmodule
